// File: rtl/fsmc_mux_master_if.sv
// Bundle of the host-side req/ack handshake and the multiplexed FSMC-style bus
// pins used by fsmc_mux_master.
//   master modport: the bus initiator (drives strobes, AD, host responses)
//   slave modport : the host/peripheral side (drives req/we/addr/wdata, AD input)
// Host side : req, we, addr[16:0], wdata[15:0] -> ready, done, rdata[15:0]
// Bus side  : ad_out[15:0], ad_oe, a16, ne, nadv, noe, nwe (active-low strobes), ad_in[15:0]
interface fsmc_mux_master_if;
  logic        req;
  logic        we;
  logic [16:0] addr;
  logic [15:0] wdata;
  logic        ready;
  logic        done;
  logic [15:0] rdata;
  logic [15:0] ad_out;
  logic        ad_oe;
  logic [15:0] ad_in;
  logic        a16;
  logic        ne;
  logic        nadv;
  logic        noe;
  logic        nwe;

  modport master (
    input  req, we, addr, wdata, ad_in,
    output ready, done, rdata, ad_out, ad_oe, a16, ne, nadv, noe, nwe
  );

  modport slave (
    output req, we, addr, wdata, ad_in,
    input  ready, done, rdata, ad_out, ad_oe, a16, ne, nadv, noe, nwe
  );
endinterface

// File: rtl/fsmc_mux_master.sv
// fsmc_mux_master: turns a single-word req/ack transaction into one complete
// multiplexed-address bus cycle: address phase (NE, NADV low, address on AD,
// A16), address hold (NADV high), data phase (NOE or NWE low), turnaround,
// then a one-cycle done pulse. A req seen in the done cycle starts the next
// address phase immediately.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fsmc_mux_master_if.master (host handshake + bus pins)
// All outputs come straight from flops.
module fsmc_mux_master #(
  parameter int unsigned ADDSET  = 2,
  parameter int unsigned ADDHLD  = 1,
  parameter int unsigned DATAST  = 4,
  parameter int unsigned BUSTURN = 1
) (
  input logic                 clk,
  input logic                 rst,
  fsmc_mux_master_if.master   bus
);

  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {IDLE, ADDR, HOLD, DATA, TURN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_we_q, op_we_d;
  logic [15:0]     op_wdata_q, op_wdata_d;

  logic            ne_q, ne_d;
  logic            nadv_q, nadv_d;
  logic            noe_q, noe_d;
  logic            nwe_q, nwe_d;
  logic            ad_oe_q, ad_oe_d;
  logic [15:0]     ad_out_q, ad_out_d;
  logic            a16_q, a16_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic [15:0]     rdata_q, rdata_d;

  // Outputs are registered, so each branch sets the pin values belonging to
  // the state being entered at this edge; staying in a state holds them.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_we_d    = op_we_q;
    op_wdata_d = op_wdata_q;
    ne_d       = ne_q;
    nadv_d     = nadv_q;
    noe_d      = noe_q;
    nwe_d      = nwe_q;
    ad_oe_d    = ad_oe_q;
    ad_out_d   = ad_out_q;
    a16_d      = a16_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    rdata_d    = rdata_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.req) begin
          state_d    = ADDR;
          cnt_d      = CW'(ADDSET - 1);
          op_we_d    = bus.we;
          op_wdata_d = bus.wdata;
          ne_d       = 1'b0;
          nadv_d     = 1'b0;
          ad_oe_d    = 1'b1;
          ad_out_d   = bus.addr[15:0];
          a16_d      = bus.addr[16];
          ready_d    = 1'b0;
        end else begin
          state_d = IDLE;
          a16_d   = 1'b0;
          ready_d = 1'b1;
        end
      end
      ADDR: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CW'(ADDHLD - 1);
          nadv_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = CW'(DATAST - 1);
          if (op_we_q) begin
            ad_out_d = op_wdata_q;
            ad_oe_d  = 1'b1;
            nwe_d    = 1'b0;
          end else begin
            ad_oe_d = 1'b0;
            noe_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          state_d = TURN;
          cnt_d   = CW'(BUSTURN - 1);
          ne_d    = 1'b1;
          noe_d   = 1'b1;
          nwe_d   = 1'b1;
          ad_oe_d = 1'b0;
          if (!op_we_q) rdata_d = bus.ad_in;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          ready_d = 1'b1;
          a16_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_we_q    <= 1'b0;
      op_wdata_q <= '0;
      ne_q       <= 1'b1;
      nadv_q     <= 1'b1;
      noe_q      <= 1'b1;
      nwe_q      <= 1'b1;
      ad_oe_q    <= 1'b0;
      ad_out_q   <= '0;
      a16_q      <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_we_q    <= op_we_d;
      op_wdata_q <= op_wdata_d;
      ne_q       <= ne_d;
      nadv_q     <= nadv_d;
      noe_q      <= noe_d;
      nwe_q      <= nwe_d;
      ad_oe_q    <= ad_oe_d;
      ad_out_q   <= ad_out_d;
      a16_q      <= a16_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.ne     = ne_q;
  assign bus.nadv   = nadv_q;
  assign bus.noe    = noe_q;
  assign bus.nwe    = nwe_q;
  assign bus.ad_oe  = ad_oe_q;
  assign bus.ad_out = ad_out_q;
  assign bus.a16    = a16_q;
  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_fsmc_mux_master.sv
// Testbench for fsmc_mux_master: a default-timing instance and an all-ones
// timing instance share the same stimulus. A per-instance reference model
// derives every cycle's expected pins from the offset into the current bus
// cycle; a vector table and hand-written sequences pin down the documented
// timing of the default instance.
module tb_fsmc_mux_master;

  localparam int unsigned AS0 = 2, AH0 = 1, DS0 = 4, BT0 = 1;
  localparam int unsigned AS1 = 1, AH1 = 1, DS1 = 1, BT1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [16:0] addr  = '0;
  logic [15:0] wdata = '0;
  logic [15:0] ad_in = '0;

  int n_cmp = 0;
  int n_bad = 0;

  fsmc_mux_master_if bus0 ();
  fsmc_mux_master_if bus1 ();

  assign bus0.req = req;  assign bus0.we = we;  assign bus0.addr = addr;
  assign bus0.wdata = wdata;  assign bus0.ad_in = ad_in;
  assign bus1.req = req;  assign bus1.we = we;  assign bus1.addr = addr;
  assign bus1.wdata = wdata;  assign bus1.ad_in = ad_in;

  fsmc_mux_master #(.ADDSET(AS0), .ADDHLD(AH0), .DATAST(DS0), .BUSTURN(BT0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  fsmc_mux_master #(.ADDSET(AS1), .ADDHLD(AH1), .DATAST(DS1), .BUSTURN(BT1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic ne, nadv, noe, nwe, ad_oe, a16, ready, done, chk_ad, cap;
    logic [15:0] ad_out;
  } mrec_t;

  function automatic int unsigned plen(input int i, input int f);
    case (f)
      0:       return (i == 0) ? AS0 : AS1;
      1:       return (i == 0) ? AH0 : AH1;
      2:       return (i == 0) ? DS0 : DS1;
      default: return (i == 0) ? BT0 : BT1;
    endcase
  endfunction

  function automatic mrec_t idle_rec(input bit fresh);
    mrec_t r;
    r = '0;
    r.ne = 1'b1; r.nadv = 1'b1; r.noe = 1'b1; r.nwe = 1'b1; r.ready = 1'b1;
    r.chk_ad = fresh;  // ad_out is 0 until the first cycle after reset
    return r;
  endfunction

  // Expected pins k cycles (k>=1) after the accepting edge.
  function automatic mrec_t rec_at(input int i, input int unsigned k, input logic twe,
                                   input logic [16:0] taddr, input logic [15:0] twd);
    mrec_t r;
    int unsigned e1, e2, e3, e4;
    logic dat;
    e1 = plen(i, 0); e2 = e1 + plen(i, 1); e3 = e2 + plen(i, 2); e4 = e3 + plen(i, 3);
    dat      = (k > e2) && (k <= e3);
    r.ne     = !(k <= e3);
    r.nadv   = !(k <= e1);
    r.noe    = !(dat && !twe);
    r.nwe    = !(dat && twe);
    r.ad_oe  = (k <= e2) || (dat && twe);
    r.a16    = (k <= e4) ? taddr[16] : 1'b0;
    r.ready  = (k == e4 + 1);
    r.done   = (k == e4 + 1);
    r.chk_ad = r.ad_oe;
    r.ad_out = (k <= e2) ? taddr[15:0] : twd;
    r.cap    = dat && !twe && (k == e3);
    return r;
  endfunction

  bit          m_act[2];
  bit          m_fresh[2];
  int unsigned m_k[2];
  logic        m_we[2];
  logic [16:0] m_addr[2];
  logic [15:0] m_wd[2];
  logic [15:0] m_rd[2];

  function automatic mrec_t cur_rec(input int i);
    if (m_act[i]) return rec_at(i, m_k[i], m_we[i], m_addr[i], m_wd[i]);
    return idle_rec(m_fresh[i]);
  endfunction

  task automatic model_edge(input int i);
    mrec_t c;
    int unsigned n;
    if (rst) begin
      m_act[i] = 0; m_fresh[i] = 1; m_rd[i] = '0;
      return;
    end
    c = cur_rec(i);
    n = plen(i, 0) + plen(i, 1) + plen(i, 2) + plen(i, 3) + 1;
    if (c.cap) m_rd[i] = ad_in;
    if (c.ready && req) begin
      m_act[i] = 1; m_k[i] = 1; m_fresh[i] = 0;
      m_we[i] = we; m_addr[i] = addr; m_wd[i] = wdata;
    end else if (m_act[i]) begin
      m_k[i]++;
      if (m_k[i] > n) m_act[i] = 0;
    end
  endtask

  task automatic compare_inst(input int i, input logic [7:0] ctl,
                              input logic [15:0] ad_o, input logic [15:0] rd);
    mrec_t c;
    bit rules_ok;
    c = cur_rec(i);
    check($sformatf("model_ctl%0d", i), 32'(ctl),
          32'({c.ne, c.nadv, c.noe, c.nwe, c.ad_oe, c.a16, c.ready, c.done}));
    if (c.chk_ad) check($sformatf("model_ad%0d", i), 32'(ad_o), 32'(c.ad_out));
    check($sformatf("model_rdata%0d", i), 32'(rd), 32'(m_rd[i]));
    // ctl = {ne, nadv, noe, nwe, ad_oe, a16, ready, done}
    rules_ok = !((!ctl[6] && (!ctl[5] || !ctl[4])) || (!ctl[5] && !ctl[4]) || (!ctl[5] && ctl[3]));
    check($sformatf("strobe_rules%0d", i), 32'(rules_ok), 32'd1);
  endtask

  function automatic logic [7:0] ctl0();
    return {bus0.ne, bus0.nadv, bus0.noe, bus0.nwe, bus0.ad_oe, bus0.a16, bus0.ready, bus0.done};
  endfunction
  function automatic logic [7:0] ctl1();
    return {bus1.ne, bus1.nadv, bus1.noe, bus1.nwe, bus1.ad_oe, bus1.a16, bus1.ready, bus1.done};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_inst(0, ctl0(), bus0.ad_out, bus0.rdata);
    compare_inst(1, ctl1(), bus1.ad_out, bus1.rdata);
  endtask

  task automatic idle(input int n);
    req = 1'b0; rst = 1'b0;
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic wait_done(input int i, input int maxc, output int n);
    bit seen;
    seen = 0; n = 0;
    for (int c = 0; c < maxc && !seen; c++) begin
      step();
      n++;
      seen = (i == 0) ? bus0.done : bus1.done;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_done%0d: got no done within %0d cycles", i, maxc);
    end
  endtask

  task automatic count_done0(input int nsteps, output int cnt);
    cnt = 0;
    for (int c = 0; c < nsteps; c++) begin
      step();
      if (bus0.done) cnt++;
    end
  endtask

  // ---------------- directed vector table (default instance) ----------------
  typedef struct {
    logic        rst, req, we;
    logic [16:0] addr;
    logic [15:0] wdata, ad_in;
    logic [7:0]  exp_ctl;  // {ne, nadv, noe, nwe, ad_oe, a16, ready, done}
    logic        chk_ad;
    logic [15:0] exp_ad, exp_rd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic q, input logic w, input logic [16:0] a,
                              input logic [15:0] wd, input logic [15:0] ai, input logic [7:0] ctl,
                              input logic ca, input logic [15:0] ea, input logic [15:0] er);
    vec_t v;
    v.rst = r; v.req = q; v.we = w; v.addr = a; v.wdata = wd; v.ad_in = ai;
    v.exp_ctl = ctl; v.chk_ad = ca; v.exp_ad = ea; v.exp_rd = er;
    return v;
  endfunction

  vec_t tbl[21];

  initial begin
    int n;
    int cnt;

    // write 0x1234 to 0x00000, then read 0x1ABCD returning 0xBEEF
    tbl[0]  = mk(1, 0, 0, 17'h00000, 16'h0000, 16'h0000, 8'hF2, 1, 16'h0000, 16'h0000);
    tbl[1]  = mk(0, 1, 1, 17'h00000, 16'h1234, 16'h0000, 8'h38, 1, 16'h0000, 16'h0000);
    tbl[2]  = mk(0, 0, 0, 17'h00000, 16'h0000, 16'h0000, 8'h38, 1, 16'h0000, 16'h0000);
    tbl[3]  = mk(0, 0, 0, 17'h00000, 16'h0000, 16'h0000, 8'h78, 1, 16'h0000, 16'h0000);
    for (int v = 4; v <= 7; v++)
      tbl[v] = mk(0, 0, 0, 17'h00000, 16'h0000, 16'h0000, 8'h68, 1, 16'h1234, 16'h0000);
    tbl[8]  = mk(0, 0, 0, 17'h00000, 16'h0000, 16'h0000, 8'hF0, 0, 16'h0000, 16'h0000);
    tbl[9]  = mk(0, 0, 0, 17'h00000, 16'h0000, 16'h0000, 8'hF3, 0, 16'h0000, 16'h0000);
    tbl[10] = mk(0, 0, 0, 17'h00000, 16'h0000, 16'h0000, 8'hF2, 0, 16'h0000, 16'h0000);
    tbl[11] = mk(0, 1, 0, 17'h1ABCD, 16'h0000, 16'h0000, 8'h3C, 1, 16'hABCD, 16'h0000);
    tbl[12] = mk(0, 0, 0, 17'h00000, 16'h0000, 16'h0000, 8'h3C, 1, 16'hABCD, 16'h0000);
    tbl[13] = mk(0, 0, 0, 17'h00000, 16'h0000, 16'h0000, 8'h7C, 1, 16'hABCD, 16'h0000);
    tbl[14] = mk(0, 0, 0, 17'h00000, 16'h0000, 16'h1111, 8'h54, 0, 16'h0000, 16'h0000);
    tbl[15] = mk(0, 0, 0, 17'h00000, 16'h0000, 16'hBEEF, 8'h54, 0, 16'h0000, 16'h0000);
    tbl[16] = mk(0, 0, 0, 17'h00000, 16'h0000, 16'hBEEF, 8'h54, 0, 16'h0000, 16'h0000);
    tbl[17] = mk(0, 0, 0, 17'h00000, 16'h0000, 16'hBEEF, 8'h54, 0, 16'h0000, 16'h0000);
    tbl[18] = mk(0, 0, 0, 17'h00000, 16'h0000, 16'hBEEF, 8'hF4, 0, 16'h0000, 16'hBEEF);
    tbl[19] = mk(0, 0, 0, 17'h00000, 16'h0000, 16'h2222, 8'hF3, 0, 16'h0000, 16'hBEEF);
    tbl[20] = mk(0, 0, 0, 17'h00000, 16'h0000, 16'h0000, 8'hF2, 0, 16'h0000, 16'hBEEF);

    for (int v = 0; v < 21; v++) begin
      rst = tbl[v].rst; req = tbl[v].req; we = tbl[v].we;
      addr = tbl[v].addr; wdata = tbl[v].wdata; ad_in = tbl[v].ad_in;
      step();
      check($sformatf("vec%0d_ctl", v), 32'(ctl0()), 32'(tbl[v].exp_ctl));
      if (tbl[v].chk_ad) check($sformatf("vec%0d_ad", v), 32'(bus0.ad_out), 32'(tbl[v].exp_ad));
      check($sformatf("vec%0d_rdata", v), 32'(bus0.rdata), 32'(tbl[v].exp_rd));
    end
    idle(4);

    // back-to-back: second request presented during the done cycle
    req = 1; we = 1; addr = 17'h00001; wdata = 16'hAAAA;
    step();
    req = 0;
    wait_done(0, 20, n);
    req = 1; we = 1; addr = 17'h00002; wdata = 16'h5555;
    step();
    req = 0;
    check("b2b_nadv", 32'(bus0.nadv), 32'd0);
    check("b2b_ready", 32'(bus0.ready), 32'd0);
    check("b2b_ad", 32'(bus0.ad_out), 32'h0002);
    wait_done(0, 20, n);
    check("b2b_done_gap", 32'(n + 1), 32'd9);
    idle(12);

    // request while busy is ignored
    req = 1; we = 1; addr = 17'h00010; wdata = 16'hA5A5;
    step();
    req = 0;
    for (int c = 0; c < 4; c++) step();
    req = 1; we = 0; addr = 17'h1FFFF; wdata = 16'hFFFF;
    step();
    req = 0;
    check("busy_ready", 32'(bus0.ready), 32'd0);
    check("busy_wdata", 32'(bus0.ad_out), 32'hA5A5);
    check("busy_a16", 32'(bus0.a16), 32'd0);
    count_done0(15, cnt);
    check("busy_done_count", 32'(cnt), 32'd1);
    idle(4);

    // reset during the data phase of a read (rdata currently 0xBEEF)
    req = 1; we = 0; addr = 17'h0F0F0; ad_in = 16'h7777;
    step();
    req = 0;
    for (int c = 0; c < 4; c++) step();
    rst = 1;
    step();
    rst = 0;
    check("rst_ctl", 32'(ctl0()), 32'h000000F2);
    check("rst_rdata", 32'(bus0.rdata), 32'h0);
    check("rst_ad", 32'(bus0.ad_out), 32'h0);
    count_done0(12, cnt);
    check("rst_no_done", 32'(cnt), 32'd0);

    // minimum timing instance: done five cycles after the accepting edge
    req = 1; we = 0; addr = 17'h00033; ad_in = 16'h4321;
    step();
    req = 0;
    wait_done(1, 20, n);
    check("fast_latency", 32'(n + 1), 32'd5);
    check("fast_rdata", 32'(bus1.rdata), 32'h4321);
    idle(12);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      req   = ($urandom_range(0, 3) == 0);
      we    = 1'($urandom_range(0, 1));
      addr  = 17'($urandom);
      wdata = 16'($urandom);
      ad_in = 16'($urandom);
      step();
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
